// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 8;
  localparam int RAM_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    CLEAR  = 2'd3
  } state_e;

  typedef logic port_t;
  localparam port_t PORT_A = 1'b0;
  localparam port_t PORT_B = 1'b1;

  // Request captured in IDLE and held untouched through ACCESS and DONE.
  typedef struct packed {
    port_t port;
    logic  we;
  } lat_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port SRAM.
// slave: arbiter view. master: requester/SRAM environment view.
interface ram_arbiter_if #(
  parameter int ADDR_W = ram_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DEF_DATA_W
);
  logic              a_req, a_we, a_ack;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_req, b_we, b_ack;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;
  logic              clr_req, clr_busy, clr_done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wr_data, ram_rd_data;
  logic              ram_wr_en;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  clr_req, ram_rd_data,
    output a_ack, a_rdata, b_ack, b_rdata,
    output clr_busy, clr_done,
    output ram_addr, ram_wr_data, ram_wr_en
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output clr_req, ram_rd_data,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  clr_busy, clr_done,
    input  ram_addr, ram_wr_data, ram_wr_en
  );
endinterface

// File: rtl/ram_arb_rr.sv
// 2-way winner select: lone request always wins; on a tie A wins when
// FIXED_PRIO=1, otherwise the port not granted last wins.
module ram_arb_rr
  import ram_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic  a_req,
  input  logic  b_req,
  input  port_t last,
  output logic  gnt_vld,
  output port_t gnt_port
);

  // Pure combinational pick; the caller decides when to sample it.
  always_comb begin
    gnt_vld  = a_req | b_req;
    gnt_port = PORT_A;
    if (a_req && b_req) begin
      if (FIXED_PRIO == 0 && last == PORT_A) gnt_port = PORT_B;
    end else if (b_req) begin
      gnt_port = PORT_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM. Each access is
// IDLE -> ACCESS -> DONE (ack in DONE), one access per 3 cycles.
// Optional zero-fill of the whole SRAM under macro RAM_ARB_CLEAR_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input logic          clk,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  lat_t              lat_q, lat_d;
  port_t             last_q, last_d;
  logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              gnt_vld;
  port_t             gnt_port;

`ifdef RAM_ARB_CLEAR_EN
  // ram_addr doubles as the fill counter; fill ends on the all-ones address.
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  logic clr_done_q, clr_done_d;
`else
  logic unused_clr_req;
  assign unused_clr_req = bus.clr_req;
`endif

  ram_arb_rr #(.FIXED_PRIO(FIXED_PRIO)) u_rr (
    .a_req    (bus.a_req),
    .b_req    (bus.b_req),
    .last     (last_q),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  // Next-state and output computation for the access/clear FSM.
  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    last_d        = last_q;
    a_ack_d       = 1'b0;
    b_ack_d       = 1'b0;
    a_rdata_d     = a_rdata_q;
    b_rdata_d     = b_rdata_q;
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
`ifdef RAM_ARB_CLEAR_EN
    clr_done_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef RAM_ARB_CLEAR_EN
        if (bus.clr_req) begin
          state_d       = CLEAR;
          ram_addr_d    = '0;
          ram_wr_data_d = '0;
        end else
`endif
        if (gnt_vld) begin
          state_d     = ACCESS;
          lat_d.port  = gnt_port;
          last_d      = gnt_port;
          if (gnt_port == PORT_A) begin
            lat_d.we      = bus.a_we;
            ram_addr_d    = bus.a_addr;
            ram_wr_data_d = bus.a_wdata;
          end else begin
            lat_d.we      = bus.b_we;
            ram_addr_d    = bus.b_addr;
            ram_wr_data_d = bus.b_wdata;
          end
        end
      end
      ACCESS: begin
        // rdata captured for writes too; the requester just ignores it.
        state_d = DONE;
        if (lat_q.port == PORT_A) begin
          a_rdata_d = bus.ram_rd_data;
          a_ack_d   = 1'b1;
        end else begin
          b_rdata_d = bus.ram_rd_data;
          b_ack_d   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      CLEAR: begin
`ifdef RAM_ARB_CLEAR_EN
        if (ram_addr_q == ADDR_MAX) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          ram_addr_d = ram_addr_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; async reset aborts any access or fill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lat_q         <= '0;
      last_q        <= PORT_B;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
`ifdef RAM_ARB_CLEAR_EN
      clr_done_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      last_q        <= last_d;
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
`ifdef RAM_ARB_CLEAR_EN
      clr_done_q    <= clr_done_d;
`endif
    end
  end

  assign bus.a_ack       = a_ack_q;
  assign bus.b_ack       = b_ack_q;
  assign bus.a_rdata     = a_rdata_q;
  assign bus.b_rdata     = b_rdata_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wr_data = ram_wr_data_q;
`ifdef RAM_ARB_CLEAR_EN
  assign bus.ram_wr_en   = (state_q == ACCESS && lat_q.we) || state_q == CLEAR;
  assign bus.clr_busy    = state_q == CLEAR;
  assign bus.clr_done    = clr_done_q;
`else
  assign bus.ram_wr_en   = state_q == ACCESS && lat_q.we;
  assign bus.clr_busy    = 1'b0;
  assign bus.clr_done    = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: u0 round-robin, u1 fixed priority, each with an SRAM model.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) bus0 ();
  ram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) bus1 ();

  ram_arbiter #(.ADDR_W(15), .DATA_W(8), .FIXED_PRIO(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ram_arbiter #(.ADDR_W(15), .DATA_W(8), .FIXED_PRIO(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [7:0] mem0 [RAM_DEPTH];
  logic [7:0] mem1 [RAM_DEPTH];
  assign bus0.ram_rd_data = mem0[bus0.ram_addr];
  assign bus1.ram_rd_data = mem1[bus1.ram_addr];
  always @(posedge clk) if (bus0.ram_wr_en) mem0[bus0.ram_addr] <= bus0.ram_wr_data;
  always @(posedge clk) if (bus1.ram_wr_en) mem1[bus1.ram_addr] <= bus1.ram_wr_data;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_a0(input logic req, input logic we, input logic [14:0] ad, input logic [7:0] d);
    bus0.a_req = req; bus0.a_we = we; bus0.a_addr = ad; bus0.a_wdata = d;
  endtask
  task automatic set_b0(input logic req, input logic we, input logic [14:0] ad, input logic [7:0] d);
    bus0.b_req = req; bus0.b_we = we; bus0.b_addr = ad; bus0.b_wdata = d;
  endtask
  task automatic set_a1(input logic req, input logic we, input logic [14:0] ad, input logic [7:0] d);
    bus1.a_req = req; bus1.a_we = we; bus1.a_addr = ad; bus1.a_wdata = d;
  endtask
  task automatic set_b1(input logic req, input logic we, input logic [14:0] ad, input logic [7:0] d);
    bus1.b_req = req; bus1.b_we = we; bus1.b_addr = ad; bus1.b_wdata = d;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0; #1;
    total++;
    if ({bus0.a_ack, bus0.b_ack, bus0.ram_wr_en, bus0.clr_busy, bus0.clr_done} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes0 got=%b exp=00000",
        {bus0.a_ack, bus0.b_ack, bus0.ram_wr_en, bus0.clr_busy, bus0.clr_done});
    end
    total++;
    if ({bus0.a_rdata, bus0.b_rdata, bus0.ram_addr, bus0.ram_wr_data} !== 39'h0) begin
      bad++; $display("FAIL reset_data0 got=%h exp=0",
        {bus0.a_rdata, bus0.b_rdata, bus0.ram_addr, bus0.ram_wr_data});
    end
    total++;
    if ({bus1.a_ack, bus1.b_ack, bus1.ram_wr_en, bus1.ram_addr} !== 18'h0) begin
      bad++; $display("FAIL reset_u1 got=%h exp=0", {bus1.a_ack, bus1.b_ack, bus1.ram_wr_en, bus1.ram_addr});
    end
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_a_write_read();
    set_a0(1, 1, 15'h0010, 8'h5A);
    tick;
    total++;
    if ({bus0.a_ack, bus0.ram_wr_en, bus0.ram_addr, bus0.ram_wr_data} !== {1'b0, 1'b1, 15'h0010, 8'h5A}) begin
      bad++; $display("FAIL wr_access got=%h exp=%h",
        {bus0.a_ack, bus0.ram_wr_en, bus0.ram_addr, bus0.ram_wr_data}, {1'b0, 1'b1, 15'h0010, 8'h5A});
    end
    tick;
    total++;
    if ({bus0.a_ack, bus0.b_ack, bus0.ram_wr_en} !== 3'b100) begin
      bad++; $display("FAIL wr_done got=%b exp=100", {bus0.a_ack, bus0.b_ack, bus0.ram_wr_en});
    end
    set_a0(0, 0, 15'h0, 8'h0);
    tick;
    total++;
    if ({bus0.a_ack, bus0.ram_wr_en, bus0.ram_addr} !== {2'b00, 15'h0010}) begin
      bad++; $display("FAIL idle_hold got=%h exp=%h", {bus0.a_ack, bus0.ram_wr_en, bus0.ram_addr}, {2'b00, 15'h0010});
    end
    set_a0(1, 0, 15'h0010, 8'h0);
    tick;
    total++;
    if ({bus0.a_ack, bus0.ram_wr_en} !== 2'b00) begin
      bad++; $display("FAIL rd_access got=%b exp=00", {bus0.a_ack, bus0.ram_wr_en});
    end
    tick;
    total++;
    if ({bus0.a_ack, bus0.b_ack, bus0.a_rdata} !== {2'b10, 8'h5A}) begin
      bad++; $display("FAIL rd_done got=%h exp=%h", {bus0.a_ack, bus0.b_ack, bus0.a_rdata}, {2'b10, 8'h5A});
    end
    set_a0(0, 0, 15'h0, 8'h0);
    tick;
  endtask

  task automatic test_round_robin();
    int ka = 0;
    int kb = 0;
    rst_n = 1'b0; #1;
    total++;
    if ({bus0.ram_addr, bus0.a_rdata} !== 23'h0) begin
      bad++; $display("FAIL rr_reset got=%h exp=0", {bus0.ram_addr, bus0.a_rdata});
    end
    tick;
    rst_n = 1'b1;
    set_a0(1, 1, 15'h0200, 8'h10);
    set_b0(1, 1, 15'h0300, 8'h20);
    for (int i = 0; i < 10; i++) begin
      logic exp_b;
      exp_b = (i % 2) == 1;
      tick; tick;
      total++;
      if ({bus0.a_ack, bus0.b_ack} !== {~exp_b, exp_b}) begin
        bad++; $display("FAIL rr_grant%0d got=%b exp=%b", i, {bus0.a_ack, bus0.b_ack}, {~exp_b, exp_b});
      end
      if (!exp_b) begin
        ka++;
        if (ka == 5) set_a0(0, 0, 15'h0, 8'h0);
        else if (ka == 4) set_a0(1, 1, 15'h0204, 8'hA4);
        else set_a0(1, 1, 15'h0200 + 15'(ka), 8'h10 + 8'(ka));
      end else begin
        kb++;
        if (kb == 5) set_b0(0, 0, 15'h0, 8'h0);
        else if (kb == 4) set_b0(1, 1, 15'h0304, 8'hB4);
        else set_b0(1, 1, 15'h0300 + 15'(kb), 8'h20 + 8'(kb));
      end
      tick;
    end
    set_a0(1, 0, 15'h0304, 8'h0);
    tick; tick;
    total++;
    if ({bus0.a_ack, bus0.a_rdata} !== {1'b1, 8'hB4}) begin
      bad++; $display("FAIL rr_readback_a got=%h exp=%h", {bus0.a_ack, bus0.a_rdata}, {1'b1, 8'hB4});
    end
    set_a0(0, 0, 15'h0, 8'h0);
    tick;
    set_b0(1, 0, 15'h0204, 8'h0);
    tick; tick;
    total++;
    if ({bus0.b_ack, bus0.b_rdata} !== {1'b1, 8'hA4}) begin
      bad++; $display("FAIL rr_readback_b got=%h exp=%h", {bus0.b_ack, bus0.b_rdata}, {1'b1, 8'hA4});
    end
    set_b0(0, 0, 15'h0, 8'h0);
    tick;
  endtask

  task automatic test_lone_request();
    // B was granted last; a lone B request must still go through.
    set_b0(1, 0, 15'h0300, 8'h0);
    tick; tick;
    total++;
    if ({bus0.a_ack, bus0.b_ack, bus0.b_rdata} !== {2'b01, 8'h20}) begin
      bad++; $display("FAIL lone_b got=%h exp=%h", {bus0.a_ack, bus0.b_ack, bus0.b_rdata}, {2'b01, 8'h20});
    end
    set_b0(0, 0, 15'h0, 8'h0);
    tick;
  endtask

  task automatic test_fixed_prio();
    set_a1(1, 1, 15'h0040, 8'h40);
    set_b1(1, 1, 15'h0050, 8'h99);
    for (int k = 0; k < 3; k++) begin
      tick; tick;
      total++;
      if ({bus1.a_ack, bus1.b_ack} !== 2'b10) begin
        bad++; $display("FAIL fixed_a%0d got=%b exp=10", k, {bus1.a_ack, bus1.b_ack});
      end
      if (k == 2) set_a1(0, 0, 15'h0, 8'h0);
      else set_a1(1, 1, 15'h0041 + 15'(k), 8'h41 + 8'(k));
      tick;
    end
    tick; tick;
    total++;
    if ({bus1.a_ack, bus1.b_ack} !== 2'b01) begin
      bad++; $display("FAIL fixed_b got=%b exp=01", {bus1.a_ack, bus1.b_ack});
    end
    set_b1(0, 0, 15'h0, 8'h0);
    tick;
  endtask

  task automatic test_clear();
`ifdef RAM_ARB_CLEAR_EN
    int   cnt = 0;
    logic saw_ack = 1'b0;
    set_a0(1, 1, 15'h7FFF, 8'hFF);
    tick; tick;
    set_a0(0, 0, 15'h0, 8'h0);
    tick;
    bus0.clr_req = 1'b1;
    set_b0(1, 0, 15'h7FFF, 8'h0);
    tick;
    bus0.clr_req = 1'b0;
    for (int c = 0; c < 40000; c++) begin
      if (!bus0.clr_busy) break;
      cnt++;
      if (bus0.b_ack) saw_ack = 1'b1;
      tick;
    end
    total++;
    if (cnt != 32768 || saw_ack !== 1'b0) begin
      bad++; $display("FAIL clr_busy_len got=%0d ack=%b exp=32768 ack=0", cnt, saw_ack);
    end
    total++;
    if (bus0.clr_done !== 1'b1) begin
      bad++; $display("FAIL clr_done got=%b exp=1", bus0.clr_done);
    end
    tick;
    total++;
    if ({bus0.clr_done, bus0.b_ack} !== 2'b00) begin
      bad++; $display("FAIL clr_done_pulse got=%b exp=00", {bus0.clr_done, bus0.b_ack});
    end
    tick;
    total++;
    if ({bus0.b_ack, bus0.b_rdata} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL clr_readback got=%h exp=%h", {bus0.b_ack, bus0.b_rdata}, {1'b1, 8'h00});
    end
    set_b0(0, 0, 15'h0, 8'h0);
    tick;
`else
    bus0.clr_req = 1'b1;
    set_b0(1, 0, 15'h0010, 8'h0);
    tick;
    bus0.clr_req = 1'b0;
    total++;
    if ({bus0.clr_busy, bus0.ram_addr} !== {1'b0, 15'h0010}) begin
      bad++; $display("FAIL clr_ignored got=%h exp=%h", {bus0.clr_busy, bus0.ram_addr}, {1'b0, 15'h0010});
    end
    tick;
    total++;
    if ({bus0.b_ack, bus0.clr_done, bus0.b_rdata} !== {2'b10, 8'h5A}) begin
      bad++; $display("FAIL clr_ignored_ack got=%h exp=%h", {bus0.b_ack, bus0.clr_done, bus0.b_rdata}, {2'b10, 8'h5A});
    end
    set_b0(0, 0, 15'h0, 8'h0);
    tick;
`endif
  endtask

  task automatic test_reset_mid_access();
    set_a0(1, 1, 15'h0100, 8'h77);
    tick; tick;
    set_a0(0, 0, 15'h0, 8'h0);
    tick;
    set_b0(1, 1, 15'h0100, 8'h33);
    tick;
    total++;
    if (bus0.ram_wr_en !== 1'b1) begin
      bad++; $display("FAIL mid_access_we got=%b exp=1", bus0.ram_wr_en);
    end
    #2 rst_n = 1'b0; #1;
    total++;
    if ({bus0.ram_wr_en, bus0.b_ack, bus0.ram_addr} !== 17'h0) begin
      bad++; $display("FAIL mid_reset got=%h exp=0", {bus0.ram_wr_en, bus0.b_ack, bus0.ram_addr});
    end
    set_b0(0, 0, 15'h0, 8'h0);
    tick; tick;
    total++;
    if (bus0.b_ack !== 1'b0) begin
      bad++; $display("FAIL mid_reset_noack got=%b exp=0", bus0.b_ack);
    end
    rst_n = 1'b1;
    set_a0(1, 0, 15'h0100, 8'h0);
    tick;
    total++;
    if ({bus0.a_ack, bus0.ram_addr} !== {1'b0, 15'h0100}) begin
      bad++; $display("FAIL post_reset_access got=%h exp=%h", {bus0.a_ack, bus0.ram_addr}, {1'b0, 15'h0100});
    end
    tick;
    total++;
    if ({bus0.a_ack, bus0.a_rdata} !== {1'b1, 8'h77}) begin
      bad++; $display("FAIL post_reset_read got=%h exp=%h", {bus0.a_ack, bus0.a_rdata}, {1'b1, 8'h77});
    end
    set_a0(0, 0, 15'h0, 8'h0);
    tick;
  endtask

  initial begin
    set_a0(0, 0, 15'h0, 8'h0);
    set_b0(0, 0, 15'h0, 8'h0);
    set_a1(0, 0, 15'h0, 8'h0);
    set_b1(0, 0, 15'h0, 8'h0);
    bus0.clr_req = 1'b0;
    bus1.clr_req = 1'b0;
    test_reset();
    test_a_write_read();
    test_round_robin();
    test_lone_request();
    test_fixed_prio();
    test_clear();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
